// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and access sequencer for the single-port data memory
//
// Port 0 is the core load/store path, port 1 the loader/debug path. One access
// is in flight at a time: IDLE (grant) -> ISSUE (memory strobe) -> RESP.
// Illegal accesses skip ISSUE and answer with an error in the next cycle.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-port request handshake (ready is combinational, IDLE only)
//   req_we_i              per-port store flag
//   req_funct3_i          per-port RISC-V funct3, port p at [3p+2:3p]
//   req_addr_i            per-port byte address, ADDR_W bits each
//   req_wdata_i           per-port store data, DATA_W bits each
//   rsp_valid_o           one-cycle response pulse to the granted port
//   rsp_rdata_o           formatted load data (0 for stores and errors)
//   rsp_err_o             misaligned / illegal access flag
//   mem_addr_o            memory word index
//   mem_re_o, mem_we_o    memory read / write strobes (read data returns next cycle)
//   mem_wstrb_o           byte write enables
//   mem_wdata_o           lane-replicated write data
//   mem_rdata_i           memory read data
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_valid_i,
    output logic [1:0]            req_ready_o,
    input  logic [1:0]            req_we_i,
    input  logic [5:0]            req_funct3_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    output logic [1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [ADDR_W-3:0]     mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                port_q, port_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;

    // Fields of the winning port
    logic                grant_port;
    logic                sel_we;
    logic [2:0]          sel_f3;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                f3_ok;
    logic                align_ok;
    logic [3:0]          lane_strb;
    logic [DATA_W-1:0]   lane_wdata;
    logic [1:0]          ready_raw;

    always_comb begin
        // With both valid the pointer decides; with one valid that port wins.
        grant_port = (req_valid_i == 2'b11) ? rr_ptr_q : req_valid_i[1];
        sel_we     = grant_port ? req_we_i[1] : req_we_i[0];
        sel_f3     = grant_port ? req_funct3_i[5:3] : req_funct3_i[2:0];
        sel_addr   = grant_port ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        sel_wdata  = grant_port ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];

        case (sel_f3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~sel_we;   // LBU/LHU have no store form
            default:                f3_ok = 1'b0;
        endcase

        case (sel_f3[1:0])
            2'b01:   align_ok = ~sel_addr[0];
            2'b10:   align_ok = (sel_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase

        case (sel_f3[1:0])
            2'b00: begin
                lane_strb  = 4'b0001 << sel_addr[1:0];
                lane_wdata = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                lane_strb  = sel_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{sel_wdata[15:0]}};
            end
            default: begin
                lane_strb  = 4'b1111;
                lane_wdata = sel_wdata;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        port_d      = port_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = '0;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wstrb_d = 4'b0000;
        mem_wdata_d = '0;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        ready_raw   = 2'b00;

        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    ready_raw = grant_port ? 2'b10 : 2'b01;
                    port_d    = grant_port;
                    we_d      = sel_we;
                    funct3_d  = sel_f3;
                    addr_lo_d = sel_addr[1:0];
                    rr_ptr_d  = ~grant_port;
                    if (f3_ok && align_ok) begin
                        state_d     = ISSUE;
                        mem_addr_d  = sel_addr[ADDR_W-1:2];
                        mem_re_d    = ~sel_we;
                        mem_we_d    = sel_we;
                        mem_wstrb_d = sel_we ? lane_strb : 4'b0000;
                        mem_wdata_d = sel_we ? lane_wdata : '0;
                    end else begin
                        state_d     = RESP;
                        rsp_valid_d = grant_port ? 2'b10 : 2'b01;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d     = RESP;
                rsp_valid_d = port_q ? 2'b10 : 2'b01;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready must not advertise a grant while reset is held.
    assign req_ready_o = ready_raw & {2{reset_i}};

    // Load formatting uses the live memory data returned in RESP.
    always_comb begin
        rsp_rdata_o = '0;
        if (state_q == RESP && !rsp_err_q && !we_q) begin
            case (funct3_q)
                3'b000, 3'b100: begin
                    logic [7:0] b;
                    case (addr_lo_q)
                        2'b00:   b = mem_rdata_i[7:0];
                        2'b01:   b = mem_rdata_i[15:8];
                        2'b10:   b = mem_rdata_i[23:16];
                        default: b = mem_rdata_i[31:24];
                    endcase
                    rsp_rdata_o = {{24{b[7] & ~funct3_q[2]}}, b};
                end
                3'b001, 3'b101: begin
                    logic [15:0] h;
                    h = addr_lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
                    rsp_rdata_o = {{16{h[15] & ~funct3_q[2]}}, h};
                end
                default: rsp_rdata_o = mem_rdata_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            port_q      <= port_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
